// File: rtl/transducer_fire_sequencer.sv
// Burst sequencer for the shared arm/release/clear strobes. trig -> onYourMark 1 cycle; all outputs registered.
// No backpressure: FIRE holds until every masked channel completes; FIRESEQ_WATCHDOG_EN adds a FIRE timeout.
module transducer_fire_sequencer #(
  parameter int          NUM_CH       = 8,
  parameter int          ARM_CYCLES   = 2,
  parameter logic [31:0] FIRE_TIMEOUT = 32'd1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig,
  input  logic              abort,
  input  logic [15:0]       numFires,
  input  logic [31:0]       firePeriod,
  input  logic [NUM_CH-1:0] chanMask,
  input  logic [NUM_CH-1:0] fireComplete_in,
  output logic              onYourMark,
  output logic              gogogo,
  output logic              chanRst,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [15:0]       fireCount,
  output logic              overrun,
  output logic              timeoutErr
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ARM   = 3'd1;
  localparam logic [2:0] FIRE  = 3'd2;
  localparam logic [2:0] CLEAR = 3'd3;
  localparam logic [2:0] WAIT  = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;
  localparam logic [2:0] ABORT = 3'd6;

  localparam logic [15:0] ArmLast = 16'(ARM_CYCLES - 1);

  logic [2:0]  state;
  logic [2:0]  nextState;
  logic [15:0] numFiresLat;
  logic [31:0] periodLat;
  logic [31:0] periodCnt;
  logic [31:0] periodLoad;
  logic [15:0] armCnt;
  logic        allDone;
  logic        wdTrip;
  logic        startReq;

  assign allDone  = &(fireComplete_in | ~chanMask);
  assign startReq = trig && (numFires != 16'd0);

  // A period of 0 behaves like 1: back-to-back events.
  always_comb begin
    periodLoad = (state == IDLE) ? firePeriod : periodLat;
    if (periodLoad != 32'd0) begin
      periodLoad = periodLoad - 32'd1;
    end
  end

`ifdef FIRESEQ_WATCHDOG_EN
  logic [31:0] wdCnt;

  assign wdTrip = (wdCnt >= (FIRE_TIMEOUT - 32'd1));

  always_ff @(posedge clk) begin
    if (!rst || (state != FIRE)) begin
      wdCnt <= 32'd0;
    end else if (wdCnt != 32'hFFFF_FFFF) begin
      wdCnt <= wdCnt + 32'd1;
    end
  end
`else
  assign wdTrip = 1'b0;
`endif

  // abort outranks completion and period expiry in every active state.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (startReq) nextState = ARM;
      end
      ARM: begin
        if (abort) nextState = ABORT;
        else if (armCnt == ArmLast) nextState = FIRE;
      end
      FIRE: begin
        if (abort) nextState = ABORT;
        else if (allDone) nextState = CLEAR;
        else if (wdTrip) nextState = ABORT;
      end
      CLEAR: begin
        if (abort) nextState = ABORT;
        else if (fireCount == numFiresLat) nextState = DONE;
        else nextState = WAIT;
      end
      WAIT: begin
        if (abort) nextState = ABORT;
        else if (periodCnt == 32'd0) nextState = ARM;
      end
      DONE:    nextState = IDLE;
      ABORT:   nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      numFiresLat <= 16'd0;
      periodLat   <= 32'd0;
      periodCnt   <= 32'd0;
      armCnt      <= 16'd0;
      onYourMark  <= 1'b0;
      gogogo      <= 1'b0;
      chanRst     <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      fireCount   <= 16'd0;
      overrun     <= 1'b0;
      timeoutErr  <= 1'b0;
    end else begin
      state      <= nextState;
      onYourMark <= (nextState == ARM) || (nextState == FIRE);
      gogogo     <= (nextState == FIRE);
      chanRst    <= (nextState == CLEAR) || (nextState == ABORT);
      busy       <= (nextState != IDLE);
      done       <= (nextState == DONE);
      aborted    <= (nextState == ABORT);

      if ((state == IDLE) && (nextState == ARM)) begin
        numFiresLat <= numFires;
        periodLat   <= firePeriod;
        fireCount   <= 16'd0;
        overrun     <= 1'b0;
        timeoutErr  <= 1'b0;
      end

      if ((nextState == ARM) && (state != ARM)) begin
        periodCnt <= periodLoad;
      end else if ((state != IDLE) && (periodCnt != 32'd0)) begin
        periodCnt <= periodCnt - 32'd1;
      end

      if (state == ARM) begin
        armCnt <= armCnt + 16'd1;
      end else begin
        armCnt <= 16'd0;
      end

      if ((state == FIRE) && (nextState == CLEAR)) begin
        fireCount <= fireCount + 16'd1;
      end

      // Period already spent when the event clears: the next ARM is late.
      if ((state == CLEAR) && (nextState == WAIT) && (periodCnt == 32'd0)) begin
        overrun <= 1'b1;
      end

      if ((state == FIRE) && !abort && !allDone && wdTrip) begin
        timeoutErr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_transducer_fire_sequencer.sv
// Timeline-model bench for transducer_fire_sequencer; FIRESEQ_WATCHDOG_EN also exercises the FIRE timeout.
module tb_transducer_fire_sequencer;
  localparam int A    = 2;
  localparam int MAXC = 600;

  logic        clk = 1'b0;
  logic        rst, trig, abort;
  logic [15:0] numFires;
  logic [31:0] firePeriod;
  logic [7:0]  chanMask;
  logic [7:0]  fireComplete_in = 8'h00;
  logic        onYourMark, gogogo, chanRst, busy, done, aborted, overrun, timeoutErr;
  logic [15:0] fireCount;

  transducer_fire_sequencer #(.NUM_CH(8), .ARM_CYCLES(A), .FIRE_TIMEOUT(32'd100)) dut (
    .clk(clk), .rst(rst), .trig(trig), .abort(abort), .numFires(numFires),
    .firePeriod(firePeriod), .chanMask(chanMask), .fireComplete_in(fireComplete_in),
    .onYourMark(onYourMark), .gogogo(gogogo), .chanRst(chanRst), .busy(busy),
    .done(done), .aborted(aborted), .fireCount(fireCount), .overrun(overrun),
    .timeoutErr(timeoutErr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected output timeline, indexed by cycle (cycle n = after the n-th rising edge)
  logic        expOym [MAXC];
  logic        expGo  [MAXC];
  logic        expRst [MAXC];
  logic        expBusy[MAXC];
  logic        expDone[MAXC];
  logic        expAbt [MAXC];
  logic        expOvr [MAXC];
  logic        expTo  [MAXC];
  logic [15:0] expCnt [MAXC];

  task automatic fillIdle(int from, logic [15:0] cnt, logic ovr, logic to);
    for (int c = from; c < MAXC; c++) begin
      expOym[c] = 1'b0; expGo[c] = 1'b0; expRst[c] = 1'b0; expBusy[c] = 1'b0;
      expDone[c] = 1'b0; expAbt[c] = 1'b0; expCnt[c] = cnt; expOvr[c] = ovr; expTo[c] = to;
    end
  endtask

  task automatic setOut(int c, logic oym, logic go, logic cr, logic bz, logic dn, logic ab);
    if (c < MAXC) begin
      expOym[c] = oym; expGo[c] = go; expRst[c] = cr;
      expBusy[c] = bz; expDone[c] = dn; expAbt[c] = ab;
    end
  endtask

  // Burst starting with ARM at t0; each FIRE lasts f cycles; abortCyc < 0 means no abort.
  task automatic planBurst(int t0, int n, int p, int f, int abortCyc);
    int t, pe, clr, nextArm;
    pe = (p < 1) ? 1 : p;
    t  = t0;
    fillIdle(t0, 16'd0, 1'b0, 1'b0);
    for (int e = 0; e < n; e++) begin
      for (int c = t; c < t + A; c++) setOut(c, 1, 0, 0, 1, 0, 0);
      for (int c = t + A; c < t + A + f; c++) setOut(c, 1, 1, 0, 1, 0, 0);
      clr = t + A + f;
      setOut(clr, 0, 0, 1, 1, 0, 0);
      for (int c = clr; c < MAXC; c++) expCnt[c] = 16'(e + 1);
      if (e == n - 1) begin
        setOut(clr + 1, 0, 0, 0, 1, 1, 0);
      end else begin
        nextArm = t + ((pe > A + f + 2) ? pe : A + f + 2);
        for (int c = clr + 1; c < nextArm; c++) setOut(c, 0, 0, 0, 1, 0, 0);
        if (A + f + 2 > pe)
          for (int c = clr + 1; c < MAXC; c++) expOvr[c] = 1'b1;
        t = nextArm;
      end
    end
    if (abortCyc >= 0) begin
      fillIdle(abortCyc + 1, expCnt[abortCyc], expOvr[abortCyc], expTo[abortCyc]);
      setOut(abortCyc + 1, 0, 0, 1, 1, 0, 1);
    end
  endtask

  always @(negedge clk) begin
    if (cyc >= 1 && cyc < MAXC) begin
      check($sformatf("c%0d onYourMark", cyc), 32'(onYourMark), 32'(expOym[cyc]));
      check($sformatf("c%0d gogogo", cyc),     32'(gogogo),     32'(expGo[cyc]));
      check($sformatf("c%0d chanRst", cyc),    32'(chanRst),    32'(expRst[cyc]));
      check($sformatf("c%0d busy", cyc),       32'(busy),       32'(expBusy[cyc]));
      check($sformatf("c%0d done", cyc),       32'(done),       32'(expDone[cyc]));
      check($sformatf("c%0d aborted", cyc),    32'(aborted),    32'(expAbt[cyc]));
      check($sformatf("c%0d fireCount", cyc),  32'(fireCount),  32'(expCnt[cyc]));
      check($sformatf("c%0d overrun", cyc),    32'(overrun),    32'(expOvr[cyc]));
      check($sformatf("c%0d timeoutErr", cyc), 32'(timeoutErr), 32'(expTo[cyc]));
    end
  end

  // Channel bank: complete compDelay cycles into the release, cleared by chanRst
  int         compDelay = 10;
  logic [7:0] compMask  = 8'hFF;
  int         chCnt     = 0;
  always @(negedge clk) begin
    if (chanRst === 1'b1) chCnt = 0;
    else if (gogogo === 1'b1) chCnt = chCnt + 1;
    fireComplete_in = (chCnt >= compDelay) ? compMask : 8'h00;
  end

  int   armQ[$];
  int   doneCnt = 0, abtCnt = 0, lastAbtCyc = -1, goCycles = 0;
  logic prevOym = 1'b0;
  always @(negedge clk) begin
    if (onYourMark === 1'b1 && prevOym !== 1'b1) armQ.push_back(cyc);
    prevOym = onYourMark;
    if (gogogo === 1'b1) goCycles++;
    if (done === 1'b1) doneCnt++;
    if (aborted === 1'b1) begin abtCnt++; lastAbtCyc = cyc; end
  end

  task automatic toCycle(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b0; trig = 1'b0; abort = 1'b0; numFires = 16'd0; firePeriod = 32'd0; chanMask = 8'hFF;
    fillIdle(0, 16'd0, 1'b0, 1'b0);
    for (int c = 1; c <= 3; c++) expRst[c] = 1'b1;
    toCycle(3); rst = 1'b1;

    // Burst of 3, period 50, 10-cycle FIRE; a second trig mid-burst is ignored
    toCycle(5); numFires = 16'd3; firePeriod = 32'd50; trig = 1'b1; planBurst(6, 3, 50, 10, -1);
    toCycle(6); trig = 1'b0; numFires = 16'd0; firePeriod = 32'd7;
    toCycle(60); trig = 1'b1; numFires = 16'd2;
    toCycle(61); trig = 1'b0;
    toCycle(125);
    check("burst arm count", armQ.size(), 3);
    check("burst first arm cycle", armQ[0], 6);
    check("burst arm spacing 1", armQ[1] - armQ[0], 50);
    check("burst arm spacing 2", armQ[2] - armQ[1], 50);
    check("burst done pulses", doneCnt, 1);
    check("burst fireCount", 32'(fireCount), 3);
    check("burst overrun", 32'(overrun), 0);
    armQ.delete();

    // Overrun: period 5, FIRE 20 cycles
    toCycle(130); numFires = 16'd2; firePeriod = 32'd5; compDelay = 20; trig = 1'b1;
    planBurst(131, 2, 5, 20, -1);
    toCycle(131); trig = 1'b0;
    toCycle(185);
    check("overrun arm spacing", armQ[1] - armQ[0], 24);
    check("overrun flag", 32'(overrun), 1);
    check("overrun fireCount", 32'(fireCount), 2);
    goCycles = 0;

    // Masked channels 4-7 never complete
    toCycle(190); numFires = 16'd1; firePeriod = 32'd10; compDelay = 3;
    chanMask = 8'h0F; compMask = 8'h0F; trig = 1'b1; planBurst(191, 1, 10, 3, -1);
    toCycle(191); trig = 1'b0;
    toCycle(200);
    check("mask0F fire length", goCycles, 3);
    check("mask0F fireCount", 32'(fireCount), 1);
    goCycles = 0; chanMask = 8'h00; compMask = 8'h00; compDelay = 50;

    // No channels enabled: CLEAR after first FIRE cycle
    toCycle(205); trig = 1'b1; planBurst(206, 1, 10, 1, -1);
    toCycle(206); trig = 1'b0;
    toCycle(215);
    check("mask00 fire length", goCycles, 1);
    check("done pulses total", doneCnt, 4);

    // Abort on the same cycle allDone rises in the second FIRE
    toCycle(220); chanMask = 8'hFF; compMask = 8'hFF; compDelay = 5; numFires = 16'd3;
    firePeriod = 32'd40; trig = 1'b1; planBurst(221, 3, 40, 5, 267);
    toCycle(221); trig = 1'b0;
    toCycle(267); abort = 1'b1;
    toCycle(268); abort = 1'b0;
    toCycle(275);
    check("abort pulses", abtCnt, 1);
    check("abort no done", doneCnt, 4);
    check("abort fireCount held", 32'(fireCount), 1);

    // Reset during WAIT
    toCycle(280); numFires = 16'd2; firePeriod = 32'd60; compDelay = 4; trig = 1'b1;
    planBurst(281, 2, 60, 4, -1);
    toCycle(281); trig = 1'b0;
    toCycle(300); rst = 1'b0; fillIdle(301, 16'd0, 1'b0, 1'b0); expRst[301] = 1'b1;
    toCycle(301); rst = 1'b1;
    check("reset chanRst", 32'(chanRst), 1);
    check("reset busy", 32'(busy), 0);
    check("reset fireCount", 32'(fireCount), 0);
    toCycle(302);
    check("post-reset chanRst", 32'(chanRst), 0);

    // numFires = 0 is ignored
    toCycle(310); numFires = 16'd0; trig = 1'b1;
    toCycle(311); trig = 1'b0;
    toCycle(315);
    check("zero-fire busy", 32'(busy), 0);

`ifdef FIRESEQ_WATCHDOG_EN
    toCycle(320); numFires = 16'd1; firePeriod = 32'd10; compMask = 8'h00; trig = 1'b1;
    planBurst(321, 1, 10, 200, 422);
    for (int c = 423; c < MAXC; c++) expTo[c] = 1'b1;
    toCycle(321); trig = 1'b0;
    toCycle(430);
    check("timeout abort cycle", lastAbtCyc, 423);
    check("timeoutErr", 32'(timeoutErr), 1);
`endif

    toCycle(450);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
